// File: rtl/vga_timing_multimode.sv
// Multi-mode VGA timing generator: 640x480, 800x600, 1280x720.
// Mode changes are deferred to the frame boundary; all outputs registered.
module vga_timing_multimode #(
    parameter int CORDW        = 12,
    parameter int DEFAULT_MODE = 0
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             en,
    input  logic [1:0]       mode_sel,
    output logic [1:0]       active_mode,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame_start,
    output logic             line_start,
    output logic             VGA_BLANK_N,
    output logic             VGA_SYNC_N
);

    typedef struct packed {
        logic [CORDW-1:0] h_act;
        logic [CORDW-1:0] h_fp;
        logic [CORDW-1:0] h_sync;
        logic [CORDW-1:0] h_tot;
        logic [CORDW-1:0] v_act;
        logic [CORDW-1:0] v_fp;
        logic [CORDW-1:0] v_sync;
        logic [CORDW-1:0] v_tot;
        logic             h_pos;
        logic             v_pos;
    } timing_t;

    function automatic timing_t timing_of(input logic [1:0] m);
        timing_t t;
        unique case (m)
            2'd1: begin
                t.h_act  = CORDW'(800);
                t.h_fp   = CORDW'(40);
                t.h_sync = CORDW'(128);
                t.h_tot  = CORDW'(1056);
                t.v_act  = CORDW'(600);
                t.v_fp   = CORDW'(1);
                t.v_sync = CORDW'(4);
                t.v_tot  = CORDW'(628);
                t.h_pos  = 1'b1;
                t.v_pos  = 1'b1;
            end
            2'd2: begin
                t.h_act  = CORDW'(1280);
                t.h_fp   = CORDW'(110);
                t.h_sync = CORDW'(40);
                t.h_tot  = CORDW'(1650);
                t.v_act  = CORDW'(720);
                t.v_fp   = CORDW'(5);
                t.v_sync = CORDW'(5);
                t.v_tot  = CORDW'(750);
                t.h_pos  = 1'b1;
                t.v_pos  = 1'b1;
            end
            default: begin
                t.h_act  = CORDW'(640);
                t.h_fp   = CORDW'(16);
                t.h_sync = CORDW'(96);
                t.h_tot  = CORDW'(800);
                t.v_act  = CORDW'(480);
                t.v_fp   = CORDW'(10);
                t.v_sync = CORDW'(2);
                t.v_tot  = CORDW'(525);
                t.h_pos  = 1'b0;
                t.v_pos  = 1'b0;
            end
        endcase
        return t;
    endfunction

    // True while p lies inside the sync pulse window of an axis
    function automatic logic in_sync(
        input logic [CORDW-1:0] p,
        input logic [CORDW-1:0] act,
        input logic [CORDW-1:0] fp,
        input logic [CORDW-1:0] sw
    );
        logic [CORDW-1:0] start;
        start = act + fp;
        return (p >= start) && (p < start + sw);
    endfunction

    localparam logic [1:0] DEF_MODE = 2'(DEFAULT_MODE);
    localparam timing_t    DEF_T    = timing_of(DEF_MODE);

    logic [1:0]       mode_q, mode_d;
    logic [CORDW-1:0] sx_q, sx_d;
    logic [CORDW-1:0] sy_q, sy_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             de_q, de_d;
    logic             fs_q, fs_d;
    logic             ls_q, ls_d;

    timing_t cur_t;
    timing_t nxt_t;

    // Next position/mode, then sync/blank decoded from that next position
    always_comb begin
        cur_t  = timing_of(mode_q);
        mode_d = mode_q;
        sx_d   = sx_q;
        sy_d   = sy_q;
        fs_d   = 1'b0;
        ls_d   = 1'b0;
        if (en) begin
            if (sx_q == cur_t.h_tot - CORDW'(1)) begin
                sx_d = '0;
                ls_d = 1'b1;
                if (sy_q == cur_t.v_tot - CORDW'(1)) begin
                    sy_d   = '0;
                    fs_d   = 1'b1;
                    mode_d = (mode_sel == 2'd3) ? 2'd0 : mode_sel;
                end else begin
                    sy_d = sy_q + CORDW'(1);
                end
            end else begin
                sx_d = sx_q + CORDW'(1);
            end
        end
        nxt_t = timing_of(mode_d);
        hs_d  = in_sync(sx_d, nxt_t.h_act, nxt_t.h_fp, nxt_t.h_sync)
              ? nxt_t.h_pos : ~nxt_t.h_pos;
        vs_d  = in_sync(sy_d, nxt_t.v_act, nxt_t.v_fp, nxt_t.v_sync)
              ? nxt_t.v_pos : ~nxt_t.v_pos;
        de_d  = (sx_d < nxt_t.h_act) && (sy_d < nxt_t.v_act);
    end

    // Timing state; reset parks at the last pixel so the first tick starts a frame
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            mode_q <= DEF_MODE;
            sx_q   <= DEF_T.h_tot - CORDW'(1);
            sy_q   <= DEF_T.v_tot - CORDW'(1);
            hs_q   <= ~DEF_T.h_pos;
            vs_q   <= ~DEF_T.v_pos;
            de_q   <= 1'b0;
            fs_q   <= 1'b0;
            ls_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            fs_q   <= fs_d;
            ls_q   <= ls_d;
        end
    end

    assign active_mode = mode_q;
    assign sx          = sx_q;
    assign sy          = sy_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign VGA_BLANK_N = de_q;
    assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_multimode.sv
// Directed bench for vga_timing_multimode: vector table plus
// hand sequences for reset, deferred switch, en gating and async reset.
module tb_vga_timing_multimode;

    localparam int CW = 12;

    logic          clk_pix = 1'b0;
    logic          rst_pix_n;
    logic          en;
    logic [1:0]    mode_sel;
    logic [1:0]    active_mode;
    logic [CW-1:0] sx;
    logic [CW-1:0] sy;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          frame_start;
    logic          line_start;
    logic          VGA_BLANK_N;
    logic          VGA_SYNC_N;

    vga_timing_multimode #(
        .CORDW(CW),
        .DEFAULT_MODE(0)
    ) dut (
        .clk_pix(clk_pix),
        .rst_pix_n(rst_pix_n),
        .en(en),
        .mode_sel(mode_sel),
        .active_mode(active_mode),
        .sx(sx),
        .sy(sy),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .frame_start(frame_start),
        .line_start(line_start),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N)
    );

    always #5 clk_pix = ~clk_pix;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reset, then release at a negedge with the given mode_sel and en
    task automatic do_reset(input logic [1:0] sel, input logic e);
        @(negedge clk_pix);
        rst_pix_n = 1'b0;
        en        = e;
        mode_sel  = sel;
        @(negedge clk_pix);
        @(negedge clk_pix);
        rst_pix_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] sel;
        int         n;
        logic [1:0] am;
        int         ex;
        int         ey;
        logic       hs;
        logic       vs;
        logic       de;
    } vec_t;

    vec_t vt[$];
    vec_t v;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lsc;
        int wide;
        logic prev;

        rst_pix_n = 1'b1;
        en        = 1'b0;
        mode_sel  = 2'd0;

        // n ticks after release -> position n-1 in raster order
        v = '{2'd0,    1, 2'd0,    0, 0, 1'b1, 1'b1, 1'b1}; vt.push_back(v);
        v = '{2'd0,  640, 2'd0,  639, 0, 1'b1, 1'b1, 1'b1}; vt.push_back(v);
        v = '{2'd0,  641, 2'd0,  640, 0, 1'b1, 1'b1, 1'b0}; vt.push_back(v);
        v = '{2'd0,  656, 2'd0,  655, 0, 1'b1, 1'b1, 1'b0}; vt.push_back(v);
        v = '{2'd0,  657, 2'd0,  656, 0, 1'b0, 1'b1, 1'b0}; vt.push_back(v);
        v = '{2'd0,  752, 2'd0,  751, 0, 1'b0, 1'b1, 1'b0}; vt.push_back(v);
        v = '{2'd0,  753, 2'd0,  752, 0, 1'b1, 1'b1, 1'b0}; vt.push_back(v);
        v = '{2'd0,  801, 2'd0,    0, 1, 1'b1, 1'b1, 1'b1}; vt.push_back(v);
        v = '{2'd1,    1, 2'd1,    0, 0, 1'b0, 1'b0, 1'b1}; vt.push_back(v);
        v = '{2'd1,  841, 2'd1,  840, 0, 1'b1, 1'b0, 1'b0}; vt.push_back(v);
        v = '{2'd1,  968, 2'd1,  967, 0, 1'b1, 1'b0, 1'b0}; vt.push_back(v);
        v = '{2'd1,  969, 2'd1,  968, 0, 1'b0, 1'b0, 1'b0}; vt.push_back(v);
        v = '{2'd1, 1057, 2'd1,    0, 1, 1'b0, 1'b0, 1'b1}; vt.push_back(v);
        v = '{2'd2, 1280, 2'd2, 1279, 0, 1'b0, 1'b0, 1'b1}; vt.push_back(v);
        v = '{2'd2, 1281, 2'd2, 1280, 0, 1'b0, 1'b0, 1'b0}; vt.push_back(v);
        v = '{2'd2, 1391, 2'd2, 1390, 0, 1'b1, 1'b0, 1'b0}; vt.push_back(v);
        v = '{2'd2, 1430, 2'd2, 1429, 0, 1'b1, 1'b0, 1'b0}; vt.push_back(v);
        v = '{2'd2, 1431, 2'd2, 1430, 0, 1'b0, 1'b0, 1'b0}; vt.push_back(v);
        v = '{2'd2, 1651, 2'd2,    0, 1, 1'b0, 1'b0, 1'b1}; vt.push_back(v);
        v = '{2'd3,    1, 2'd0,    0, 0, 1'b1, 1'b1, 1'b1}; vt.push_back(v);
        v = '{2'd3,  657, 2'd0,  656, 0, 1'b0, 1'b1, 1'b0}; vt.push_back(v);

        // Reset state
        @(negedge clk_pix);
        rst_pix_n = 1'b0;
        en        = 1'b1;
        @(negedge clk_pix);
        chk("rst_sx", 32'(sx), 799);
        chk("rst_sy", 32'(sy), 524);
        chk("rst_mode", 32'(active_mode), 0);
        chk("rst_de", 32'(de), 0);
        chk("rst_blank", 32'(VGA_BLANK_N), 0);
        chk("rst_hs", 32'(hsync), 1);
        chk("rst_vs", 32'(vsync), 1);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_ls", 32'(line_start), 0);
        chk("rst_syncn", 32'(VGA_SYNC_N), 0);

        // First tick after release
        rst_pix_n = 1'b1;
        @(negedge clk_pix);
        chk("t1_sx", 32'(sx), 0);
        chk("t1_sy", 32'(sy), 0);
        chk("t1_de", 32'(de), 1);
        chk("t1_fs", 32'(frame_start), 1);
        chk("t1_ls", 32'(line_start), 1);
        @(negedge clk_pix);
        chk("t2_fs", 32'(frame_start), 0);
        chk("t2_ls", 32'(line_start), 0);
        chk("t2_sx", 32'(sx), 1);
        repeat (799) @(negedge clk_pix);
        chk("l1_sx", 32'(sx), 0);
        chk("l1_sy", 32'(sy), 1);
        chk("l1_ls", 32'(line_start), 1);
        chk("l1_fs", 32'(frame_start), 0);

        // Vector table
        foreach (vt[i]) begin
            do_reset(vt[i].sel, 1'b1);
            repeat (vt[i].n) @(negedge clk_pix);
            chk($sformatf("v%0d_mode", i), 32'(active_mode), 32'(vt[i].am));
            chk($sformatf("v%0d_sx", i), 32'(sx), 32'(vt[i].ex));
            chk($sformatf("v%0d_sy", i), 32'(sy), 32'(vt[i].ey));
            chk($sformatf("v%0d_hs", i), 32'(hsync), 32'(vt[i].hs));
            chk($sformatf("v%0d_vs", i), 32'(vsync), 32'(vt[i].vs));
            chk($sformatf("v%0d_de", i), 32'(de), 32'(vt[i].de));
            chk($sformatf("v%0d_blank", i), 32'(VGA_BLANK_N),
                32'(vt[i].de));
        end

        // en low right after release: position holds, no strobes
        do_reset(2'd0, 1'b0);
        repeat (3) @(negedge clk_pix);
        chk("hold_sx", 32'(sx), 799);
        chk("hold_fs", 32'(frame_start), 0);
        en = 1'b1;
        @(negedge clk_pix);
        chk("hold_rel_sx", 32'(sx), 0);
        chk("hold_rel_fs", 32'(frame_start), 1);

        // Mid-frame mode_sel change is ignored
        do_reset(2'd0, 1'b1);
        repeat (1000) @(negedge clk_pix);
        mode_sel = 2'd2;
        repeat (1000) @(negedge clk_pix);
        chk("defer_mode", 32'(active_mode), 0);
        chk("defer_sx", 32'(sx), 399);
        chk("defer_sy", 32'(sy), 2);
        mode_sel = 2'd0;

        // en every second clock in mode 1
        do_reset(2'd1, 1'b1);
        @(negedge clk_pix);
        chk("gate_fs", 32'(frame_start), 1);
        chk("gate_mode", 32'(active_mode), 1);
        en = 1'b0;
        @(negedge clk_pix);
        chk("gate_fs_fall", 32'(frame_start), 0);
        chk("gate_ls_fall", 32'(line_start), 0);
        chk("gate_sx_hold", 32'(sx), 0);
        chk("gate_de_hold", 32'(de), 1);
        lsc  = 0;
        wide = 0;
        prev = 1'b0;
        for (int i = 0; i < 4224; i++) begin
            en = (i % 2 == 0);
            @(negedge clk_pix);
            if (line_start) lsc++;
            if (line_start && prev) wide++;
            prev = line_start;
        end
        chk("gate_ls_cnt", 32'(lsc), 2);
        chk("gate_ls_wide", 32'(wide), 0);
        chk("gate_sx", 32'(sx), 0);
        chk("gate_sy", 32'(sy), 2);
        en = 1'b0;
        @(negedge clk_pix);
        chk("gate_ls_end", 32'(line_start), 0);
        chk("gate_sx_end", 32'(sx), 0);

        // Asynchronous reset mid-frame in mode 1
        do_reset(2'd1, 1'b1);
        repeat (2413) @(negedge clk_pix);
        chk("mid_sx", 32'(sx), 300);
        chk("mid_sy", 32'(sy), 2);
        chk("mid_mode", 32'(active_mode), 1);
        mode_sel = 2'd2;
        @(posedge clk_pix);
        #2 rst_pix_n = 1'b0;
        #1;
        chk("arst_sx", 32'(sx), 799);
        chk("arst_sy", 32'(sy), 524);
        chk("arst_mode", 32'(active_mode), 0);
        chk("arst_hs", 32'(hsync), 1);
        chk("arst_vs", 32'(vsync), 1);
        chk("arst_de", 32'(de), 0);
        chk("arst_ls", 32'(line_start), 0);
        @(negedge clk_pix);
        rst_pix_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_multimode.md
Name: vga_timing_multimode

Overview:
- Generates pixel coordinates and VGA sync, blank and strobe signals for one of three built-in display modes.
- The mode can be switched at runtime. A new mode takes effect only at a frame boundary, so no partial frame is ever produced.
- Sits in the pixel clock domain between the clock/PLL block and the pixel renderer. Drives the VGA DAC control pins directly.
- Successor to the fixed 640x480 timing generator. Adds mode selection, a pixel clock enable and frame/line strobes.

Parameters:
- CORDW, 12, width of the sx/sy counters. Must be ≥11; the largest total is 1650.
- DEFAULT_MODE, 0, mode loaded at reset (0..2).

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  pixel tick enable. Counters advance only when en=1.
- mode_sel  in  2  requested mode. Sampled only at the frame boundary.
- active_mode  out  2  mode currently being generated.
- sx  out  CORDW  horizontal position, 0..H_TOTAL-1.
- sy  out  CORDW  vertical position, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, mode polarity applied.
- vsync  out  1  vertical sync, mode polarity applied.
- de  out  1  data enable. High when sx<H_ACT and sy<V_ACT.
- frame_start  out  1  one-clk pulse when position becomes (0,0).
- line_start  out  1  one-clk pulse when sx becomes 0 (any line).
- VGA_BLANK_N  out  1  equals de.
- VGA_SYNC_N  out  1  constant 0.

Behaviour:
- Mode table (ACT/FP/SYNC/BP, TOTAL, sync polarity):
  - Mode 0 H 640/16/96/48, 800; V 480/10/2/33, 525; negative/negative.
  - Mode 1 H 800/40/128/88, 1056; V 600/1/4/23, 628; positive/positive.
  - Mode 2 H 1280/110/40/220, 1650; V 720/5/5/20, 750; positive/positive.
  - mode_sel=3 is reserved and is loaded as 0.
- Reset (rst_pix_n low, asynchronous):
  - sx = H_TOTAL-1 and sy = V_TOTAL-1 of DEFAULT_MODE.
  - active_mode = DEFAULT_MODE.
  - de=0, VGA_BLANK_N=0.
  - hsync/vsync at their inactive level for DEFAULT_MODE.
  - frame_start=0, line_start=0.
- All outputs are registered. hsync, vsync and de always describe the sx/sy value present in the same cycle; no skew between coordinates and sync.
- Tick (rising clk_pix with en=1):
  - sx increments.
  - At sx=H_TOTAL-1: sx wraps to 0 and sy increments.
  - At sy=V_TOTAL-1 with sx=H_TOTAL-1: sy wraps to 0.
- hsync is active for H_ACT+H_FP ≤ sx < H_ACT+H_FP+H_SYNC. vsync uses the same rule on sy with the V values.
- Mode switch:
  - Only on the tick where (sx,sy) = (H_TOTAL-1, V_TOTAL-1) of the current mode does active_mode load mode_sel (3→0).
  - On that same edge sx,sy go to 0,0 and all outputs follow the new mode's table, including polarity.
  - mode_sel changes at any other time have no effect. The value present at the boundary tick wins.
- Strobes:
  - line_start goes high on the clk following a tick that sets sx to 0.
  - frame_start goes high on the clk following a tick that sets (sx,sy) to (0,0).
  - Both clear on the next clk regardless of en, so they never stretch while en is low.
- en=0: sx, sy, active_mode, hsync, vsync and de hold their values. Strobes fall.
- First tick after reset release moves the position to (0,0) and pulses frame_start and line_start.
- Reset mid-frame: immediately returns to the reset state. The pending mode_sel is discarded.

Test Plan:
- Reset with DEFAULT_MODE=0, en=1 constant:
  - During reset: sx=799, sy=524, de=0, hsync=1, vsync=1.
  - First tick after release: sx=0, sy=0, de=1, frame_start pulse.
  - frame_start repeats every 420000 clocks.
- Mode 0 line:
  - hsync low for exactly 96 clocks starting at sx=656.
  - de high for sx 0..639 only.
  - vsync low for sy 490..491.
- Deferred switch:
  - Set mode_sel=2 at sy=100.
  - active_mode stays 0 until the tick after (799,524).
  - Next frame: sx wraps at 1649, sy at 749, hsync positive for sx 1390..1429.
  - frame period is 1237500 clocks.
- en gating with en=1 every 2nd clock:
  - Counters advance at half rate.
  - frame_start and line_start are each exactly 1 clk wide.
  - Mode 1 frame takes 2×663168 clocks.
- mode_sel=3 at the boundary: active_mode=0 and mode 0 timing is generated.
- Reset asserted at (300,200) in mode 1: outputs return to the reset values immediately, and active_mode returns to DEFAULT_MODE.
